// File: rtl/chan_mux_scan_pkg.sv
// Shared types and constants for the channel multiplexer with scan mode.
// The FSM state encoding and the meaning of the mode input live here.
package chan_mux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } mux_state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Enable dominates mode: a disabled mux is idle whatever mode says.
  function automatic mux_state_t decode_state(input logic en, input logic mode);
    if (!en) begin
      return IDLE;
    end
    return (mode == MODE_SCAN) ? SCAN : MANUAL;
  endfunction

endpackage

// File: rtl/chan_mux_scan_if.sv
// Control/data bundle between a source-side master and the multiplexer.
// The master drives the controls and packed channel data; the mux drives results.
interface chan_mux_scan_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS),
  parameter int DWELL_W  = 8
);

  logic                      en;
  logic                      mode;
  logic [SEL_W-1:0]          sel_in;
  logic [DWELL_W-1:0]        dwell;
  logic [CHANNELS*WIDTH-1:0] din;
  logic [WIDTH-1:0]          dout;
  logic                      dout_valid;
  logic [SEL_W-1:0]          cur_sel;
  logic                      wrap;

  modport master (
    output en, mode, sel_in, dwell, din,
    input  dout, dout_valid, cur_sel, wrap
  );

  modport slave (
    input  en, mode, sel_in, dwell, din,
    output dout, dout_valid, cur_sel, wrap
  );

endinterface

// File: rtl/chan_mux_scan_counter.sv
// Round-robin scan index and dwell counter. The idx/wrap outputs describe the
// channel that will be presented after the coming clock edge, so the top can register them.
module scan_counter #(
  parameter int  CHANNELS = 4,
  parameter int  DWELL_W  = 8,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               restart,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   idx,
  output logic               wrap
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0]   idx_q;
  logic [SEL_W-1:0]   idx_nxt;
  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_nxt;
  logic               at_last;
  logic               advance;

  // The dwell compare is live, so lowering dwell below cnt advances immediately.
  always_comb begin
    idx_nxt = idx_q;
    cnt_nxt = cnt_q;
    at_last = (idx_q == LAST_IDX);
    advance = run && !restart && (cnt_q >= dwell);
    if (run && restart) begin
      idx_nxt = '0;
      cnt_nxt = '0;
    end else if (advance) begin
      idx_nxt = at_last ? '0 : idx_q + SEL_W'(1);
      cnt_nxt = '0;
    end else if (run) begin
      cnt_nxt = cnt_q + DWELL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      idx_q <= idx_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  assign idx  = idx_nxt;
  assign wrap = advance && at_last;

endmodule

// File: rtl/chan_mux_scan.sv
// Registered N-channel multiplexer with enable, manual select and a round-robin
// scan mode with programmable dwell. All outputs are registered, one cycle latency.
module chan_mux_scan
  import chan_mux_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS),
  parameter int DWELL_W  = 8
) (
  input logic            clk,
  input logic            rst_n,
  chan_mux_scan_if.slave bus
);

  localparam logic [SEL_W:0] CHAN_COUNT = (SEL_W + 1)'(CHANNELS);

  mux_state_t       state_q;
  mux_state_t       state_nxt;
  logic [WIDTH-1:0] chan [CHANNELS];
  logic             sel_legal;
  logic             scan_run;
  logic             scan_restart;
  logic [SEL_W-1:0] scan_idx;
  logic             scan_wrap;

  logic [WIDTH-1:0] dout_d,  dout_q;
  logic             valid_d, valid_q;
  logic [SEL_W-1:0] sel_d,   sel_q;
  logic             wrap_d,  wrap_q;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    assign chan[k] = bus.din[k*WIDTH +: WIDTH];
  end

  assign sel_legal    = ({1'b0, bus.sel_in} < CHAN_COUNT);
  assign scan_run     = (state_nxt == SCAN);
  assign scan_restart = (state_q != SCAN);

  scan_counter #(
    .CHANNELS (CHANNELS),
    .DWELL_W  (DWELL_W)
  ) u_scan_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (scan_run),
    .restart (scan_restart),
    .dwell   (bus.dwell),
    .idx     (scan_idx),
    .wrap    (scan_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Outputs are computed for the state being entered on this edge; cur_sel holds while idle.
  always_comb begin
    state_nxt = decode_state(bus.en, bus.mode);
    dout_d    = '0;
    valid_d   = 1'b0;
    sel_d     = sel_q;
    wrap_d    = 1'b0;
    unique case (state_nxt)
      MANUAL: begin
        sel_d = bus.sel_in;
        if (sel_legal) begin
          dout_d  = chan[bus.sel_in];
          valid_d = 1'b1;
        end
      end
      SCAN: begin
        sel_d   = scan_idx;
        dout_d  = chan[scan_idx];
        valid_d = 1'b1;
        wrap_d  = scan_wrap;
      end
      default: begin
        dout_d  = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      sel_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.cur_sel    = sel_q;
  assign bus.wrap       = wrap_q;

endmodule

// File: tb/tb_chan_mux_scan.sv
// Directed bench for chan_mux_scan: a 4-channel instance for most scenarios and a
// 3-channel instance to exercise the out-of-range manual select.
module tb_chan_mux_scan;

  localparam logic [3:0] CH_A = 4'b1000;
  localparam logic [3:0] CH_B = 4'b1010;
  localparam logic [3:0] CH_C = 4'b1100;
  localparam logic [3:0] CH_D = 4'b1111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   compared = 0;
  int   mismatched = 0;
  logic [3:0] chan_val [4] = '{CH_A, CH_B, CH_C, CH_D};

  always #5 clk = ~clk;

  chan_mux_scan_if #(.WIDTH(4), .CHANNELS(4), .DWELL_W(8)) bus4 ();
  chan_mux_scan_if #(.WIDTH(4), .CHANNELS(3), .DWELL_W(8)) bus3 ();

  chan_mux_scan #(.WIDTH(4), .CHANNELS(4), .DWELL_W(8)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  chan_mux_scan #(.WIDTH(4), .CHANNELS(3), .DWELL_W(8)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus4.en = 1'b0; bus4.mode = 1'b0; bus4.sel_in = 2'd0; bus4.dwell = 8'd0;
    bus4.din = {CH_D, CH_C, CH_B, CH_A};
    bus3.en = 1'b0; bus3.mode = 1'b0; bus3.sel_in = 2'd0; bus3.dwell = 8'd0;
    bus3.din = {CH_C, CH_B, CH_A};
    rst_n = 1'b0;
    #12;
    compared++;
    if (bus4.dout !== 4'b0000 || bus4.dout_valid !== 1'b0 || bus4.cur_sel !== 2'd0 || bus4.wrap !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_state: got dout=%b valid=%b sel=%0d wrap=%b expected 0000/0/0/0",
               bus4.dout, bus4.dout_valid, bus4.cur_sel, bus4.wrap);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      compared++;
      if (bus4.dout !== 4'b0000 || bus4.dout_valid !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL en_off[%0d]: got dout=%b valid=%b expected 0000/0", i, bus4.dout, bus4.dout_valid);
      end
    end
  endtask

  task automatic test_manual_sweep();
    bus4.en = 1'b1;
    bus4.mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus4.sel_in = 2'(i);
      tick();
      compared++;
      if (bus4.dout !== chan_val[i] || bus4.dout_valid !== 1'b1 || bus4.cur_sel !== 2'(i)) begin
        mismatched++;
        $display("[TB] FAIL manual[%0d]: got dout=%b valid=%b sel=%0d expected %b/1/%0d",
                 i, bus4.dout, bus4.dout_valid, bus4.cur_sel, chan_val[i], i);
      end
    end
  endtask

  task automatic test_out_of_range();
    bus3.en = 1'b1;
    bus3.mode = 1'b0;
    bus3.sel_in = 2'd2;
    tick();
    compared++;
    if (bus3.dout !== CH_C || bus3.dout_valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL range_last_legal: got dout=%b valid=%b expected %b/1", bus3.dout, bus3.dout_valid, CH_C);
    end
    bus3.sel_in = 2'd3;
    tick();
    compared++;
    if (bus3.dout !== 4'b0000 || bus3.dout_valid !== 1'b0 || bus3.cur_sel !== 2'd3) begin
      mismatched++;
      $display("[TB] FAIL range_illegal: got dout=%b valid=%b sel=%0d expected 0000/0/3",
               bus3.dout, bus3.dout_valid, bus3.cur_sel);
    end
    bus3.en = 1'b0;
  endtask

  task automatic test_scan_dwell2();
    int exp_idx [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    bus4.en = 1'b1;
    bus4.mode = 1'b1;
    bus4.dwell = 8'd2;
    for (int i = 0; i < 13; i++) begin
      tick();
      compared++;
      if (bus4.dout !== chan_val[exp_idx[i]] || bus4.cur_sel !== 2'(exp_idx[i]) ||
          bus4.dout_valid !== 1'b1 || bus4.wrap !== (i == 12)) begin
        mismatched++;
        $display("[TB] FAIL scan2[%0d]: got dout=%b sel=%0d valid=%b wrap=%b expected %b/%0d/1/%b",
                 i, bus4.dout, bus4.cur_sel, bus4.dout_valid, bus4.wrap,
                 chan_val[exp_idx[i]], exp_idx[i], (i == 12));
      end
    end
  endtask

  task automatic test_scan_dwell0();
    bus4.mode = 1'b0;
    tick();
    bus4.mode = 1'b1;
    bus4.dwell = 8'd0;
    for (int i = 0; i < 8; i++) begin
      tick();
      compared++;
      if (bus4.dout !== chan_val[i % 4] || bus4.wrap !== (i == 4)) begin
        mismatched++;
        $display("[TB] FAIL scan0[%0d]: got dout=%b wrap=%b expected %b/%b",
                 i, bus4.dout, bus4.wrap, chan_val[i % 4], (i == 4));
      end
    end
    // Now showing D; dropping en at the wrap point must not wrap.
    bus4.en = 1'b0;
    tick();
    compared++;
    if (bus4.dout !== 4'b0000 || bus4.dout_valid !== 1'b0 || bus4.wrap !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL en_drop_at_wrap: got dout=%b valid=%b wrap=%b expected 0000/0/0",
               bus4.dout, bus4.dout_valid, bus4.wrap);
    end
    bus4.en = 1'b1;
    tick();
    compared++;
    if (bus4.dout !== CH_A || bus4.wrap !== 1'b0 || bus4.cur_sel !== 2'd0) begin
      mismatched++;
      $display("[TB] FAIL reenable_restart: got dout=%b wrap=%b sel=%0d expected %b/0/0",
               bus4.dout, bus4.wrap, bus4.cur_sel, CH_A);
    end
  endtask

  task automatic test_disturbances();
    int exp_idx [3] = '{0, 0, 1};
    bus4.mode = 1'b0;
    tick();
    bus4.mode = 1'b1;
    bus4.dwell = 8'd2;
    repeat (7) tick();
    compared++;
    if (bus4.dout !== CH_C) begin
      mismatched++;
      $display("[TB] FAIL disturb_on_c: got dout=%b expected %b", bus4.dout, CH_C);
    end
    bus4.en = 1'b0;
    tick();
    compared++;
    if (bus4.dout !== 4'b0000 || bus4.dout_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL disturb_en_drop: got dout=%b valid=%b expected 0000/0", bus4.dout, bus4.dout_valid);
    end
    bus4.en = 1'b1;
    tick();
    compared++;
    if (bus4.dout !== CH_A || bus4.dout_valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL disturb_restart: got dout=%b valid=%b expected %b/1", bus4.dout, bus4.dout_valid, CH_A);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if (bus4.dout !== chan_val[exp_idx[i]]) begin
        mismatched++;
        $display("[TB] FAIL disturb_resume[%0d]: got dout=%b expected %b", i, bus4.dout, chan_val[exp_idx[i]]);
      end
    end
    rst_n = 1'b0;
    #1;
    compared++;
    if (bus4.dout !== 4'b0000 || bus4.dout_valid !== 1'b0 || bus4.cur_sel !== 2'd0 || bus4.wrap !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL async_reset: got dout=%b valid=%b sel=%0d wrap=%b expected 0000/0/0/0",
               bus4.dout, bus4.dout_valid, bus4.cur_sel, bus4.wrap);
    end
    #2;
    rst_n = 1'b1;
    tick();
    compared++;
    if (bus4.dout !== CH_A || bus4.cur_sel !== 2'd0 || bus4.dout_valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_resume: got dout=%b sel=%0d valid=%b expected %b/0/1",
               bus4.dout, bus4.cur_sel, bus4.dout_valid, CH_A);
    end
  endtask

  task automatic test_dwell_change();
    int exp_idx [10] = '{0, 0, 0, 1, 1, 2, 2, 2, 2, 3};
    bus4.mode = 1'b0;
    tick();
    bus4.mode = 1'b1;
    bus4.dwell = 8'd5;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) bus4.dwell = 8'd1;
      if (i == 6) bus4.dwell = 8'd3;
      tick();
      compared++;
      if (bus4.dout !== chan_val[exp_idx[i]] || bus4.cur_sel !== 2'(exp_idx[i])) begin
        mismatched++;
        $display("[TB] FAIL dwell_change[%0d]: got dout=%b sel=%0d expected %b/%0d",
                 i, bus4.dout, bus4.cur_sel, chan_val[exp_idx[i]], exp_idx[i]);
      end
    end
    // A din change on the displayed channel shows on the next edge.
    bus4.din[15:12] = 4'b0101;
    tick();
    compared++;
    if (bus4.dout !== 4'b0101) begin
      mismatched++;
      $display("[TB] FAIL din_follow: got dout=%b expected 0101", bus4.dout);
    end
  endtask

  initial begin
    test_reset();
    test_manual_sweep();
    test_out_of_range();
    test_scan_dwell2();
    test_scan_dwell0();
    test_disturbances();
    test_dwell_change();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
